// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
//   Shared definitions for the stream_mux block and its arbiter:
//   - state_t            : packet-lock FSM encoding (IDLE=0, LOCKED=1)
//   - arb_name_t         : type of the ARBITRATION parameter
//   - ARB_ROUND_ROBIN    : rotating-pointer arbitration
//   - ARB_PRIORITY       : fixed priority, lowest channel index wins
//   - chan_slice()       : extracts one channel word from a flat channel bus
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Arbitration names are held as fixed-width packed strings so that the
    // parameter can be compared with a plain equality at elaboration time.
    localparam int ARB_NAME_W = 88;
    typedef logic [ARB_NAME_W-1:0] arb_name_t;

    localparam arb_name_t ARB_ROUND_ROBIN = "ROUND_ROBIN";
    localparam arb_name_t ARB_PRIORITY    = {24'h0, "PRIORITY"};

    // Upper bounds for chan_slice; callers cast their bus and result to size.
    localparam int CHAN_BUS_MAX  = 4096;
    localparam int CHAN_WORD_MAX = 256;

    // Returns bus[width*(idx+1)-1 : width*idx], zero-extended to CHAN_WORD_MAX.
    function automatic logic [CHAN_WORD_MAX-1:0] chan_slice(
        input logic [CHAN_BUS_MAX-1:0] bus,
        input int unsigned             idx,
        input int unsigned             width
    );
        logic [CHAN_BUS_MAX-1:0]  shifted;
        logic [CHAN_WORD_MAX-1:0] mask;
        shifted = bus >> (idx * width);
        mask    = {CHAN_WORD_MAX{1'b1}} >> (CHAN_WORD_MAX - width);
        return shifted[CHAN_WORD_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational arbiter over 2**SELECT_LINES request lines.
//   ROUND_ROBIN: first requester found searching ptr, ptr+1, ... (mod N).
//   PRIORITY   : lowest-index requester; ptr is ignored.
// Ports:
//   req         in  N             request vector (one bit per channel)
//   ptr         in  SELECT_LINES  round-robin starting index
//   grant       out SELECT_LINES  index of the winning channel (0 if none)
//   grant_valid out 1             at least one request present
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int        SELECT_LINES = 2,
    parameter arb_name_t ARBITRATION  = ARB_ROUND_ROBIN
) (
    input  logic [(2**SELECT_LINES)-1:0] req,
    input  logic [SELECT_LINES-1:0]      ptr,
    output logic [SELECT_LINES-1:0]      grant,
    output logic                         grant_valid
);

    localparam int N = 2**SELECT_LINES;
    localparam bit USE_PRIORITY = (ARBITRATION == ARB_PRIORITY);

    logic [SELECT_LINES-1:0] idx;
    logic                    found;

    // The SELECT_LINES-wide index addition wraps naturally from N-1 to 0.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = USE_PRIORITY ? SELECT_LINES'(k) : ptr + SELECT_LINES'(k);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign grant_valid = |req;

endmodule

// File: rtl/stream_mux.sv
// stream_mux
//   Merges 2**SELECT_LINES valid/ready streams into one registered stream.
//   Arbitration is round-robin or fixed priority; with PACKET_MODE=1 the
//   grant is held from the first beat of a packet to the beat with last set.
// Ports:
//   clk        in  1                system clock, rising edge
//   rst        in  1                asynchronous active-high reset
//   data_in    in  DATA_WIDTH*N     channel i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   valid_in   in  N                per-channel valid
//   last_in    in  N                per-channel end of packet (PACKET_MODE=1 only)
//   ready_out  out N                per-channel ready, combinational
//   data_out   out DATA_WIDTH       registered output word
//   valid_out  out 1                registered output valid
//   last_out   out 1                registered last flag
//   select_out out SELECT_LINES     channel that supplied data_out
//   ready_in   in  1                downstream ready
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int        SELECT_LINES = 2,
    parameter int        DATA_WIDTH   = 8,
    parameter arb_name_t ARBITRATION  = ARB_ROUND_ROBIN,
    parameter int        PACKET_MODE  = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_WIDTH*(2**SELECT_LINES)-1:0] data_in,
    input  logic [(2**SELECT_LINES)-1:0]           valid_in,
    input  logic [(2**SELECT_LINES)-1:0]           last_in,
    output logic [(2**SELECT_LINES)-1:0]           ready_out,
    output logic [DATA_WIDTH-1:0]                  data_out,
    output logic                                   valid_out,
    output logic                                   last_out,
    output logic [SELECT_LINES-1:0]                select_out,
    input  logic                                   ready_in
);

    state_t                  state;
    state_t                  state_next;
    logic [SELECT_LINES-1:0] rr_ptr;
    logic [SELECT_LINES-1:0] lock_sel;
    logic [SELECT_LINES-1:0] arb_grant;
    logic                    arb_valid;
    logic [SELECT_LINES-1:0] g;
    logic                    grant_valid;
    logic                    space;
    logic                    transfer;
    logic                    grant_end;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_last;

    rr_arbiter #(
        .SELECT_LINES (SELECT_LINES),
        .ARBITRATION  (ARBITRATION)
    ) u_arbiter (
        .req         (valid_in),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // While locked the arbiter is bypassed: only the locked channel may move,
    // so a bubble on that channel stalls the output instead of re-arbitrating.
    always_comb begin
        g           = arb_grant;
        grant_valid = arb_valid;
        if (state == LOCKED) begin
            g           = lock_sel;
            grant_valid = valid_in[lock_sel];
        end
    end

    assign space     = !valid_out || ready_in;
    assign transfer  = grant_valid && space;
    assign grant_end = transfer && ((PACKET_MODE == 0) || sel_last);

    always_comb begin
        sel_data     = DATA_WIDTH'(chan_slice(CHAN_BUS_MAX'(data_in), 32'(g), DATA_WIDTH));
        sel_last     = (PACKET_MODE != 0) ? last_in[g] : 1'b0;
        ready_out    = '0;
        if (transfer) begin
            ready_out[g] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (PACKET_MODE != 0) begin
            unique case (state)
                IDLE:    if (transfer && !sel_last) state_next = LOCKED;
                LOCKED:  if (transfer && sel_last)  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end else begin
            state_next = IDLE;
        end
    end

    // The pointer moves past the served channel only when its grant ends,
    // so a multi-beat packet counts as a single turn in the rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lock_sel <= '0;
            rr_ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && transfer) begin
                lock_sel <= g;
            end
            if (grant_end) begin
                rr_ptr <= g + SELECT_LINES'(1);
            end
        end
    end

    // A drain and a new load on the same edge resolve as a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            last_out   <= 1'b0;
            select_out <= '0;
        end else if (transfer) begin
            data_out   <= sel_data;
            valid_out  <= 1'b1;
            last_out   <= sel_last;
            select_out <= g;
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- Clocked, parametrised successor to the combinational select mux.
- Merges 2**SELECT_LINES valid/ready streams into one registered output stream.
- Arbitration is internal: round-robin or fixed-priority, with optional packet locking.
- Sits ahead of shared datapath resources (packetiser, FIFO, 10GbE TX) that several producers must feed.

Parameters:
- SELECT_LINES, 2: log2 of channel count; N = 2**SELECT_LINES; minimum 1.
- DATA_WIDTH, 8: width of each channel word.
- ARBITRATION, "ROUND_ROBIN": "ROUND_ROBIN" or "PRIORITY" (lowest index wins).
- PACKET_MODE, 1: 1 = grant held from first beat to the beat with last set; 0 = re-arbitrate every beat.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH*N  channel i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- valid_in  input  N  per-channel valid.
- last_in  input  N  per-channel end-of-packet flag; ignored when PACKET_MODE=0.
- ready_out  output  N  per-channel ready; combinational.
- data_out  output  DATA_WIDTH  registered output word.
- valid_out  output  1  registered output valid.
- last_out  output  1  registered last flag.
- select_out  output  SELECT_LINES  channel index of the word currently in data_out.
- ready_in  input  1  downstream ready.

Behaviour:
- Reset (async assert, sync release to next edge):
  - data_out=0, valid_out=0, last_out=0, select_out=0.
  - RR pointer=0, FSM=IDLE.
- Output register:
  - space = !valid_out || ready_in.
  - A transfer on channel g occurs when grant_valid && space. On that edge: data_out/last_out/select_out load from channel g, and valid_out=1.
  - When valid_out && ready_in and there is no new transfer, valid_out clears. data_out/last_out/select_out hold their values.
  - Latency from input to output is 1 cycle. Throughput is 1 word/cycle with ready_in held high.
- ready_out[i] = (i==g) && grant_valid && space. All other bits are 0. Never assert ready_out for a channel that is not valid.
- Arbiter, combinational (FSM state IDLE):
  - PRIORITY: g = lowest i with valid_in[i].
  - ROUND_ROBIN: g = first i with valid_in[i], searching ptr, ptr+1, ... with wrap mod N.
  - grant_valid = |valid_in.
- FSM, PACKET_MODE=1:
  - IDLE: transfer with last_in[g]=0 -> LOCKED, lock_sel=g. Transfer with last_in[g]=1 -> stay IDLE (single-beat packet).
  - LOCKED: g = lock_sel and grant_valid = valid_in[lock_sel]. Other channels are ignored even if valid. A source bubble stalls the output; re-arbitration is not allowed. Transfer with last_in[lock_sel]=1 -> IDLE.
- FSM, PACKET_MODE=0: FSM stays IDLE permanently; last_in is ignored and last_out=0.
- RR pointer update:
  - Updates on the grant-ending transfer: the last beat (PACKET_MODE=1) or every beat (PACKET_MODE=0).
  - New value is ptr = (g+1) mod N, wrapping from N-1 to 0.
  - The pointer is unused in PRIORITY mode but must still reset to 0.
- Simultaneous events:
  - Output drain and new load on the same edge are a load; valid_out stays 1.
  - All channels valid in RR mode: channels are served in strict rotation.
- Backpressure: with ready_in=0 and valid_out=1, all ready_out=0 and every output holds stable.
- Reset mid-packet: FSM returns to IDLE and the in-flight word is dropped. Packet integrity after reset is the sources' responsibility.
- Width rules:
  - The index is SELECT_LINES wide, so the pointer wrap is natural overflow.
  - No truncation of data.

Decomposition:
- Shared package stream_mux_pkg holds:
  - FSM state encoding (IDLE=0, LOCKED=1).
  - Arbitration mode constants.
  - Function chan_slice(bus, i) for flat-bus extraction.
- One sub-module: rr_arbiter (SELECT_LINES, ARBITRATION).
  - Inputs: request vector, pointer.
  - Outputs: grant index and grant_valid; combinational.
  - Lets the bench unit-test fairness separately.

Test Plan (SELECT_LINES=2, DATA_WIDTH=8):
1. Reset check: assert rst asynchronously mid-cycle with valid_out=1 -> valid_out, data_out, select_out go to 0 immediately; first grant after release goes to ch0.
2. RR fairness, PACKET_MODE=0: all four channels continuously valid with data 0xA0..0xA3, ready_in=1 -> data_out sequence A0,A1,A2,A3,A0 on consecutive cycles, 1-cycle latency, select_out 0,1,2,3,0.
3. PRIORITY mode: ch1 and ch3 valid -> ch1 drains every cycle and ch3 gets ready_out only after ch1 deasserts valid.
4. Packet lock: ch2 sends a 3-beat packet 0x11,0x22,0x33 with last on beat 3 while ch0 is valid throughout; insert a ch2 bubble on beat 2 -> output 11,(gap),22,33 with last_out on 33; the next grant is ch3 if valid, otherwise ch0.
5. Backpressure: ready_in low for 3 cycles mid-stream -> data_out stable, all ready_out=0, no beat lost or duplicated.
6. Reset during LOCKED state -> FSM returns to IDLE; a new single-beat packet on ch0 transfers normally with last_out=1.
